// File: rtl/mult_arb_sched.sv
// mult_arb_sched
//   Round-robin scheduler that shares one pipelined 16x16 multiplier between
//   NREQ requesters. Accepts operand pairs over per-requester valid/ready,
//   issues at most one operation per cycle, and carries each operation's
//   requester id through a fixed-latency tag pipeline. When the product comes
//   back it is returned to its owner as a one-cycle response pulse.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   MUL_LAT  cycles from mul_valid_o to the matching mul_p_i (1..8)
//
// Ports
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   en_i         grant enable; low blocks new grants, in-flight work drains
//   req_valid_i  per-requester operand-pair valid
//   req_ready_o  one-hot grant (combinational)
//   req_a_i      operand A, requester k at [16k+15:16k]
//   req_b_i      operand B, same packing
//   mul_valid_o  issue strobe to the multiplier datapath
//   mul_a_o      issued operand A
//   mul_b_o      issued operand B
//   mul_p_i      product, valid MUL_LAT cycles after issue
//   rsp_valid_o  one-hot one-cycle product-ready pulse
//   rsp_p_o      product for the pulsing requester (holds otherwise)
//   busy_o       an operation is pending issue or in flight
//
// Configuration
//   MULT_ARB_RSP_REG_EN  when defined, responses pass through one extra
//                        register stage (latency +1) and busy_o covers it.

module mult_arb_sched #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [NREQ-1:0]    req_valid_i,
  output logic [NREQ-1:0]    req_ready_o,
  input  logic [NREQ*16-1:0] req_a_i,
  input  logic [NREQ*16-1:0] req_b_i,
  output logic               mul_valid_o,
  output logic [15:0]        mul_a_o,
  output logic [15:0]        mul_b_o,
  input  logic [31:0]        mul_p_i,
  output logic [NREQ-1:0]    rsp_valid_o,
  output logic [31:0]        rsp_p_o,
  output logic               busy_o
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   rr_next;
  logic [IW-1:0]   grant_id;
  logic [IW-1:0]   search_idx;
  logic            grant_found;
  logic            accept;
  logic [15:0]     grant_a;
  logic [15:0]     grant_b;
  logic [IW-1:0]   issue_id;

  logic [MUL_LAT-1:0]         tag_v;
  logic [MUL_LAT-1:0][IW-1:0] tag_id;
  logic                       last_v;
  logic [IW-1:0]              last_id;
  logic [NREQ-1:0]            rsp_oh;
  logic [31:0]                rsp_p_q;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    search_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      search_idx = IW'((int'(rr_ptr) + i) % NREQ);
      if (!grant_found && req_valid_i[search_idx]) begin
        grant_found = 1'b1;
        grant_id    = search_idx;
      end
    end
  end

  // Grants are suppressed while disabled or held in reset.
  assign req_ready_o = (grant_found && en_i && !rst_i)
                     ? (NREQ'(1) << grant_id) : '0;
  assign accept      = |(req_valid_i & req_ready_o);
  assign rr_next     = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);

  // Operand mux for the granted requester.
  always_comb begin
    grant_a = '0;
    grant_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == grant_id) begin
        grant_a = req_a_i[i*16 +: 16];
        grant_b = req_b_i[i*16 +: 16];
      end
    end
  end

  // Issue register and round-robin pointer.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr      <= '0;
      mul_valid_o <= 1'b0;
      mul_a_o     <= '0;
      mul_b_o     <= '0;
      issue_id    <= '0;
    end else begin
      mul_valid_o <= accept;
      if (accept) begin
        rr_ptr   <= rr_next;
        mul_a_o  <= grant_a;
        mul_b_o  <= grant_b;
        issue_id <= grant_id;
      end
    end
  end

  // Tag pipeline valid bits: cleared by reset so in-flight work is dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= mul_valid_o;
      for (int s = 1; s < MUL_LAT; s++) begin
        tag_v[s] <= tag_v[s-1];
      end
    end
  end

  // NOTE: the id payload is qualified by tag_v, so it needs no reset; only
  // the valid bits carry control meaning.
  always_ff @(posedge clk_i) begin
    tag_id[0] <= issue_id;
    for (int s = 1; s < MUL_LAT; s++) begin
      tag_id[s] <= tag_id[s-1];
    end
  end

  assign last_v  = tag_v[MUL_LAT-1];
  assign last_id = tag_id[MUL_LAT-1];
  assign rsp_oh  = last_v ? (NREQ'(1) << last_id) : '0;

  // Last returned product; supplies the hold value between responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_p_q <= '0;
    end else if (last_v) begin
      rsp_p_q <= mul_p_i;
    end
  end

`ifdef MULT_ARB_RSP_REG_EN
  logic [NREQ-1:0] rsp_v_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_v_q <= '0;
    end else begin
      rsp_v_q <= rsp_oh;
    end
  end

  assign rsp_valid_o = rsp_v_q;
  assign rsp_p_o     = rsp_p_q;
  assign busy_o      = mul_valid_o | (|tag_v) | (|rsp_v_q);
`else
  assign rsp_valid_o = rsp_oh;
  assign rsp_p_o     = last_v ? mul_p_i : rsp_p_q;
  assign busy_o      = mul_valid_o | (|tag_v);
`endif

endmodule

// File: tb/tb_mult_arb_sched.sv
// Directed testbench for mult_arb_sched (NREQ=4, MUL_LAT=3). A small
// multiplier model returns a*b MUL_LAT cycles after each issue strobe.
// Builds with or without MULT_ARB_RSP_REG_EN; RL is the extra response delay.

module tb_mult_arb_sched;

  localparam int NREQ    = 4;
  localparam int MUL_LAT = 3;
`ifdef MULT_ARB_RSP_REG_EN
  localparam int RL = 1;
`else
  localparam int RL = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [3:0]  req_valid_i;
  logic [3:0]  req_ready_o;
  logic [63:0] req_a_i;
  logic [63:0] req_b_i;
  logic        mul_valid_o;
  logic [15:0] mul_a_o;
  logic [15:0] mul_b_o;
  logic [31:0] mul_p_i;
  logic [3:0]  rsp_valid_o;
  logic [31:0] rsp_p_o;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  mult_arb_sched #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .mul_valid_o (mul_valid_o),
    .mul_a_o     (mul_a_o),
    .mul_b_o     (mul_b_o),
    .mul_p_i     (mul_p_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_p_o     (rsp_p_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Multiplier datapath model: product of the issued operands, MUL_LAT later.
  logic [31:0] p_pipe [MUL_LAT];
  logic        v_pipe [MUL_LAT];
  always @(posedge clk_i) begin
    p_pipe[0] <= 32'(mul_a_o) * 32'(mul_b_o);
    v_pipe[0] <= mul_valid_o;
    for (int i = 1; i < MUL_LAT; i++) begin
      p_pipe[i] <= p_pipe[i-1];
      v_pipe[i] <= v_pipe[i-1];
    end
  end
  assign mul_p_i = (v_pipe[MUL_LAT-1] === 1'b1) ? p_pipe[MUL_LAT-1] : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [3:0] oh(input int k);
    return 4'(1) << k;
  endfunction

  function automatic logic [63:0] pack4(input logic [15:0] w3, input logic [15:0] w2,
                                        input logic [15:0] w1, input logic [15:0] w0);
    return {w3, w2, w1, w0};
  endfunction

  // Watchdog: the sequence below is bounded, this only guards against a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp_rv;
    logic [3:0] exp_rdy;
    logic       exp_mv;
    int         r;

    // ---------------- reset state ----------------
    rst_i       = 1'b1;
    en_i        = 1'b1;
    req_valid_i = 4'hF;
    req_a_i     = pack4(16'd1, 16'd1, 16'd1, 16'd1);
    req_b_i     = pack4(16'd1, 16'd1, 16'd1, 16'd1);
    step();
    check("rst_ready",  32'(req_ready_o), 32'h0);
    check("rst_mv",     32'(mul_valid_o), 32'h0);
    check("rst_mul_a",  32'(mul_a_o),     32'h0);
    check("rst_mul_b",  32'(mul_b_o),     32'h0);
    check("rst_rsp_v",  32'(rsp_valid_o), 32'h0);
    check("rst_rsp_p",  rsp_p_o,          32'h0);
    check("rst_busy",   32'(busy_o),      32'h0);
    step();
    rst_i       = 1'b0;
    req_valid_i = 4'h0;
    step();

    // ---------------- single request: req 2, 3*5 ----------------
    req_valid_i = 4'b0100;
    req_a_i     = pack4(16'd9, 16'd3, 16'd9, 16'd9);
    req_b_i     = pack4(16'd9, 16'd5, 16'd9, 16'd9);
    #1;
    check("single_ready", 32'(req_ready_o), 32'b0100);
    step();  // N+1
    req_valid_i = 4'h0;
    check("single_mv",    32'(mul_valid_o), 32'h1);
    check("single_mul_a", 32'(mul_a_o),     32'd3);
    check("single_mul_b", 32'(mul_b_o),     32'd5);
    check("single_busy1", 32'(busy_o),      32'h1);
    for (int d = 2; d <= 5 + RL; d++) begin
      step();
      if (d == 2) check("single_mv_off", 32'(mul_valid_o), 32'h0);
      exp_rv = (d == 4 + RL) ? 4'b0100 : 4'b0000;
      check("single_rsp_v", 32'(rsp_valid_o), 32'(exp_rv));
      if (d >= 4 + RL) check("single_rsp_p", rsp_p_o, 32'd15);
      check("single_busy", 32'(busy_o), (d <= 4 + RL) ? 32'h1 : 32'h0);
    end

    // ---------------- fairness: all four valid from reset ----------------
    rst_i       = 1'b1;
    req_valid_i = 4'hF;
    #1;
    check("fair_rst_ready", 32'(req_ready_o), 32'h0);
    step();
    rst_i = 1'b0;
    req_a_i = pack4(16'd4, 16'd3, 16'd2, 16'd1);
    req_b_i = pack4(16'd10, 16'd10, 16'd10, 16'd10);
    for (int j = 0; j <= 9 + RL; j++) begin
      exp_mv = (j >= 1 && j <= 5);
      check("fair_mv", 32'(mul_valid_o), 32'(exp_mv));
      if (exp_mv) check("fair_mul_a", 32'(mul_a_o), 32'((j - 1) % 4 + 1));
      r      = j - 4 - RL;
      exp_rv = (r >= 0 && r < 5) ? oh(r % 4) : 4'b0000;
      check("fair_rsp_v", 32'(rsp_valid_o), 32'(exp_rv));
      if (r >= 0 && r < 5) check("fair_rsp_p", rsp_p_o, 32'(10 * (r % 4 + 1)));
      check("fair_busy", 32'(busy_o), (j >= 1 && j <= 8 + RL) ? 32'h1 : 32'h0);
      req_valid_i = (j < 5) ? 4'hF : 4'h0;
      #1;
      exp_rdy = (j < 5) ? oh(j % 4) : 4'b0000;
      check("fair_ready", 32'(req_ready_o), 32'(exp_rdy));
      step();
    end

    // ---------------- solo streaming: req 1, a=k, b=2 ----------------
    req_b_i = pack4(16'd0, 16'd0, 16'd2, 16'd0);
    for (int j = 0; j <= 14 + RL; j++) begin
      exp_mv = (j >= 1 && j <= 10);
      check("solo_mv", 32'(mul_valid_o), 32'(exp_mv));
      if (exp_mv) check("solo_mul_a", 32'(mul_a_o), 32'(j - 1));
      r      = j - 4 - RL;
      exp_rv = (r >= 0 && r < 10) ? 4'b0010 : 4'b0000;
      check("solo_rsp_v", 32'(rsp_valid_o), 32'(exp_rv));
      if (r >= 0 && r < 10) check("solo_rsp_p", rsp_p_o, 32'(2 * r));
      check("solo_busy", 32'(busy_o), (j >= 1 && j <= 13 + RL) ? 32'h1 : 32'h0);
      req_valid_i = (j < 10) ? 4'b0010 : 4'b0000;
      req_a_i     = pack4(16'd0, 16'd0, 16'(j), 16'd0);
      #1;
      exp_rdy = (j < 10) ? 4'b0010 : 4'b0000;
      check("solo_ready", 32'(req_ready_o), 32'(exp_rdy));
      step();
    end

    // ---------------- enable gating (rr_ptr now 2) ----------------
    for (int j = 0; j <= 13 + RL; j++) begin
      exp_mv = (j == 1 || j == 2 || j == 9);
      check("en_mv", 32'(mul_valid_o), 32'(exp_mv));
      if (j == 1) check("en_mul_a1", 32'(mul_a_o), 32'd7);
      if (j == 2) check("en_mul_a2", 32'(mul_a_o), 32'd4);
      if (j == 9) check("en_mul_a3", 32'(mul_a_o), 32'd2);
      exp_rv = 4'b0000;
      if (j == 4 + RL)  exp_rv = 4'b1000;
      if (j == 5 + RL)  exp_rv = 4'b0001;
      if (j == 12 + RL) exp_rv = 4'b1000;
      check("en_rsp_v", 32'(rsp_valid_o), 32'(exp_rv));
      if (j == 4 + RL)  check("en_rsp_p1", rsp_p_o, 32'd21);
      if (j == 5 + RL)  check("en_rsp_p2", rsp_p_o, 32'd16);
      if (j == 12 + RL) check("en_rsp_p3", rsp_p_o, 32'd4);
      check("en_busy", 32'(busy_o),
            ((j >= 1 && j <= 5 + RL) || (j >= 9 && j <= 12 + RL)) ? 32'h1 : 32'h0);
      if (j == 0) begin
        en_i = 1'b1; req_valid_i = 4'b1000;
        req_a_i = pack4(16'd7, 16'd0, 16'd0, 16'd0);
        req_b_i = pack4(16'd3, 16'd0, 16'd0, 16'd0);
        exp_rdy = 4'b1000;
      end else if (j == 1) begin
        req_valid_i = 4'b0001;
        req_a_i = pack4(16'd0, 16'd0, 16'd0, 16'd4);
        req_b_i = pack4(16'd0, 16'd0, 16'd0, 16'd4);
        exp_rdy = 4'b0001;
      end else if (j <= 8) begin
        en_i = (j == 8);
        req_valid_i = 4'b1001;
        req_a_i = pack4(16'd2, 16'd0, 16'd0, 16'd9);
        req_b_i = pack4(16'd2, 16'd0, 16'd0, 16'd9);
        exp_rdy = (j == 8) ? 4'b1000 : 4'b0000;
      end else begin
        req_valid_i = 4'b0000;
        exp_rdy = 4'b0000;
      end
      #1;
      check("en_ready", 32'(req_ready_o), 32'(exp_rdy));
      step();
    end

    // ---------------- reset mid-flight (rr_ptr now 0) ----------------
    req_a_i = pack4(16'd5, 16'd6, 16'd7, 16'd0);
    req_b_i = pack4(16'd5, 16'd6, 16'd7, 16'd0);
    for (int j = 0; j < 3; j++) begin
      req_valid_i = 4'b1110;
      #1;
      check("rmid_ready", 32'(req_ready_o), 32'(oh(j + 1)));
      step();
    end
    req_valid_i = 4'hF;
    rst_i       = 1'b1;
    #1;
    check("rmid_ready0", 32'(req_ready_o), 32'h0);
    check("rmid_mv",     32'(mul_valid_o), 32'h0);
    check("rmid_mul_a",  32'(mul_a_o),     32'h0);
    check("rmid_mul_b",  32'(mul_b_o),     32'h0);
    check("rmid_rsp_v",  32'(rsp_valid_o), 32'h0);
    check("rmid_rsp_p",  rsp_p_o,          32'h0);
    check("rmid_busy",   32'(busy_o),      32'h0);
    step();
    rst_i       = 1'b0;
    req_valid_i = 4'h0;
    for (int j = 0; j < 6; j++) begin
      step();
      check("rmid_no_rsp",  32'(rsp_valid_o), 32'h0);
      check("rmid_idle",    32'(busy_o),      32'h0);
    end
    req_valid_i = 4'hF;
    #1;
    check("rmid_first_grant", 32'(req_ready_o), 32'b0001);
    step();
    req_valid_i = 4'h0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
